// File: rtl/lc3_pkg.sv
// Shared LC3 types and constants used by the memory-access slice of the pipeline.
package lc3_pkg;

    localparam int LC3_ADDR_W  = 16;
    localparam int LC3_DATA_W  = 16;
    localparam int LC3_TIMEOUT = 255;

    typedef enum logic [1:0] {
        MEM_RD   = 2'd0,
        MEM_IND  = 2'd1,
        MEM_WR   = 2'd2,
        MEM_IDLE = 2'd3
    } mem_state_t;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_RTI  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RES  = 4'hD;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

    function automatic logic is_mem_op(input mem_state_t s);
        return s != MEM_IDLE;
    endfunction

endpackage

// File: rtl/lc3_mem_timeout.sv
// Loadable down-counter bounding how long one data-memory access may wait for ack.
module lc3_mem_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Loaded with TIMEOUT-1 so expire lands in the TIMEOUT-th cycle of the request.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/lc3_mem_access.sv
// LC3 memory-access stage: runs the dmem req/ack handshake for loads, stores and the
// two-phase LDI/STI pointer flow, and pulses complete_data to release the controller.
module lc3_mem_access
    import lc3_pkg::*;
#(
    parameter int ADDR_W  = LC3_ADDR_W,
    parameter int DATA_W  = LC3_DATA_W,
    parameter int TIMEOUT = LC3_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_state,
    input  logic [ADDR_W-1:0] M_Addr,
    input  logic [DATA_W-1:0] M_Data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_din,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_dout,
    output logic              complete_data,
    output logic [DATA_W-1:0] memout,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t              state_q, state_d;
    mem_state_t        phase_q, phase_d;
    mem_state_t        last_done_q, last_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ind_addr_q, ind_addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] memout_q, memout_d;
    logic              we_q, we_d;
    logic              ind_valid_q, ind_valid_d;
    logic              flush_q, flush_d;
    logic              err_q, err_d;

    mem_state_t        ms;
    logic              launch, expire, finish, flushed;
    logic [DATA_W-1:0] rdata;

    assign ms      = mem_state_t'(mem_state);
    assign launch  = (state_q == S_IDLE) && is_mem_op(ms) && (ms != last_done_q);
    assign finish  = (state_q == S_REQ) && (dmem_ack || expire);
    assign flushed = flush_q || (ms == MEM_IDLE);
    // A timed-out access completes as if the memory had returned zero.
    assign rdata   = dmem_ack ? dmem_dout : '0;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            lc3_mem_timeout #(
                .TIMEOUT (TIMEOUT)
            ) u_timeout (
                .clk    (clk),
                .rst    (rst),
                .load   (launch),
                .en     (state_q == S_REQ),
                .expire (expire)
            );
        end else begin : g_no_timeout
            assign expire = 1'b0;
        end
    endgenerate

    always_comb begin
        // NOTE: every target gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        last_done_d = last_done_q;
        addr_d      = addr_q;
        ind_addr_d  = ind_addr_q;
        din_d       = din_q;
        memout_d    = memout_q;
        we_d        = we_q;
        ind_valid_d = ind_valid_q;
        flush_d     = flush_q;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_REQ;
                    phase_d = ms;
                    we_d    = (ms == MEM_WR);
                    din_d   = M_Data;
                    addr_d  = (ind_valid_q && (ms != MEM_IND)) ? ind_addr_q : M_Addr;
                    flush_d = 1'b0;
                end
            end
            S_REQ: begin
                if (ms == MEM_IDLE) begin
                    flush_d = 1'b1;
                end
                if (finish) begin
                    state_d = flushed ? S_IDLE : S_DONE;
                    flush_d = 1'b0;
                    if (!dmem_ack) begin
                        err_d = 1'b1;
                    end
                    if (flushed) begin
                        ind_valid_d = 1'b0;
                    end else begin
                        if (!we_q || !dmem_ack) begin
                            memout_d = rdata;
                        end
                        if (phase_q == MEM_IND) begin
                            ind_addr_d  = ADDR_W'(rdata);
                            ind_valid_d = 1'b1;
                        end else begin
                            ind_valid_d = 1'b0;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                last_done_d = phase_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A non-memory slot re-arms launch so identical back-to-back ops relaunch.
        if (ms == MEM_IDLE) begin
            last_done_d = MEM_IDLE;
        end
    end

    // NOTE: non-blocking assignments make every flop sample the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            phase_q     <= MEM_IDLE;
            last_done_q <= MEM_IDLE;
            addr_q      <= '0;
            ind_addr_q  <= '0;
            din_q       <= '0;
            memout_q    <= '0;
            we_q        <= 1'b0;
            ind_valid_q <= 1'b0;
            flush_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            last_done_q <= last_done_d;
            addr_q      <= addr_d;
            ind_addr_q  <= ind_addr_d;
            din_q       <= din_d;
            memout_q    <= memout_d;
            we_q        <= we_d;
            ind_valid_q <= ind_valid_d;
            flush_q     <= flush_d;
            err_q       <= err_d;
        end
    end

    assign dmem_req      = (state_q == S_REQ);
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_din      = din_q;
    assign complete_data = (state_q == S_DONE);
    assign memout        = memout_q;
    assign busy          = (state_q != S_IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Scoreboard bench for lc3_mem_access: a reference model predicts each completed phase,
// a memory responder answers requests, and a monitor checks every complete_data pulse.
module tb_lc3_mem_access;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mem_state = 2'd3;
    logic [15:0] M_Addr = '0;
    logic [15:0] M_Data = '0;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_din, dmem_dout;
    logic        complete_data, busy, err;
    logic [15:0] memout;

    lc3_mem_access #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_state     (mem_state),
        .M_Addr        (M_Addr),
        .M_Data        (M_Data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_din      (dmem_din),
        .dmem_ack      (dmem_ack),
        .dmem_dout     (dmem_dout),
        .complete_data (complete_data),
        .memout        (memout),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        acked;
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] memout;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
    } acc_t;

    exp_t exp_q[$];
    acc_t acc_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   cmp_cyc = 0;
    int   t_issue = 0;
    int   ack_delay = 0;
    int   cur_len = 0;
    int   last_req_len = 0;

    logic [15:0] phys_mem[logic [15:0]];
    logic [15:0] ref_mem[logic [15:0]];

    // Reference model state: what the spec says the stage remembers between phases.
    logic        m_ind_v = 1'b0;
    logic [15:0] m_ind_a = '0;
    logic [15:0] m_memout = '0;
    logic        m_err = 1'b0;
    logic [1:0]  m_last = 2'd3;

    function automatic logic [15:0] def_word(input logic [15:0] a);
        return 16'h3000 | ((a ^ (a >> 4)) & 16'h000F);
    endfunction

    function automatic logic [15:0] phys_rd(input logic [15:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : def_word(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : def_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acks the (ack_delay+1)-th cycle of each request.
    initial begin
        dmem_ack  = 1'b0;
        dmem_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            if (rst && dmem_req) begin
                cur_len++;
                if (cur_len == ack_delay + 1) begin
                    dmem_ack  = 1'b1;
                    dmem_dout = dmem_we ? 16'($urandom) : phys_rd(dmem_addr);
                    if (dmem_we) phys_mem[dmem_addr] = dmem_din;
                    acc_q.push_back('{dmem_we, dmem_addr, dmem_din});
                end
            end else if (cur_len > 0) begin
                last_req_len = cur_len;
                cur_len      = 0;
            end
        end
    end

    // Monitor: every complete_data cycle must match the oldest predicted phase.
    exp_t mon_e;
    acc_t mon_a;
    always @(negedge clk) begin
        if (rst && complete_data) begin
            cmp_cyc = cyc;
            check("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("memout", memout, mon_e.memout);
                check("err", err, mon_e.err);
                if (mon_e.acked) begin
                    check("access_seen", {31'd0, acc_q.size() != 0}, 32'd1);
                    if (acc_q.size() != 0) begin
                        mon_a = acc_q.pop_front();
                        check("acc_we", mon_a.we, mon_e.we);
                        check("acc_addr", mon_a.addr, mon_e.addr);
                        if (mon_e.we) check("acc_din", mon_a.din, mon_e.din);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        bit done = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        check("idle_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        mem_state = 2'd3;
        m_last    = 2'd3;
    endtask

    task automatic issue(input logic [1:0] ph, input logic [15:0] a, input logic [15:0] d,
                         input int dly);
        exp_t        e;
        logic [15:0] ea;
        if (ph == m_last) go_idle();
        ea      = (m_ind_v && ph != 2'd1) ? m_ind_a : a;
        e.acked = (dly < TMO);
        e.we    = (ph == 2'd2);
        e.addr  = ea;
        e.din   = d;
        if (!e.acked) begin
            m_err    = 1'b1;
            m_memout = '0;
            m_ind_v  = 1'b0;
        end else if (ph == 2'd0) begin
            m_memout = ref_rd(ea);
            m_ind_v  = 1'b0;
        end else if (ph == 2'd1) begin
            m_memout = ref_rd(ea);
            m_ind_a  = m_memout;
            m_ind_v  = 1'b1;
        end else begin
            ref_mem[ea] = d;
            m_ind_v     = 1'b0;
        end
        e.memout = m_memout;
        e.err    = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        ack_delay = dly;
        M_Addr    = a;
        M_Data    = d;
        mem_state = ph;
        t_issue   = cyc;
        m_last    = ph;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        phys_mem[16'h3000] = 16'hBEEF; ref_mem[16'h3000] = 16'hBEEF;
        phys_mem[16'h5000] = 16'h6000; ref_mem[16'h5000] = 16'h6000;
        phys_mem[16'h6000] = 16'hCAFE; ref_mem[16'h6000] = 16'hCAFE;

        #12;
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_din", dmem_din, 0);
        check("rst_complete", complete_data, 0);
        check("rst_memout", memout, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1; rst = 1'b1;

        // LD with three-cycle request
        issue(2'd0, 16'h3000, 16'h0, 2);
        check("ld_req_len", last_req_len, 3);
        check("ld_latency", cmp_cyc - t_issue, 4);
        check("ld_busy_after", busy, 0);

        // ST with zero-wait ack
        issue(2'd2, 16'h4001, 16'h1234, 0);
        check("st_latency", cmp_cyc - t_issue, 2);

        // LDI then STI through pointer at 5000, then direct read sees the STI data
        issue(2'd1, 16'h5000, 16'h0, 1);
        issue(2'd0, 16'h7777, 16'h0, 2);
        issue(2'd1, 16'h5000, 16'h0, 0);
        issue(2'd2, 16'h7777, 16'h00AA, 1);
        issue(2'd0, 16'h6000, 16'h0, 0);

        // Flush: indirect read abandoned by mem_state=3, then a plain LD relaunches
        issue(2'd1, 16'h5000, 16'h0, 1);
        @(posedge clk); #1;
        ack_delay = 4; M_Addr = 16'h3000; mem_state = 2'd0;
        repeat (3) @(posedge clk);
        #1; mem_state = 2'd3;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("flush_idle", busy, 0);
        check("flush_access", acc_q.size(), 1);
        if (acc_q.size() != 0) check("flush_addr", acc_q[0].addr, 16'h6000);
        acc_q.delete();
        m_ind_v = 1'b0;
        m_last  = 2'd3;
        issue(2'd0, 16'h3000, 16'h0, 0);

        // Ack in the expiry cycle wins over the timeout
        issue(2'd0, 16'h3001, 16'h0, TMO - 1);
        check("edge_req_len", last_req_len, TMO);
        check("edge_err", err, 0);

        for (int n = 0; n < 120; n++) begin
            logic [1:0] ph;
            ph = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) go_idle();
            issue(ph, 16'h3000 + 16'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 5));
        end

        // Timeout: no ack at all
        issue(2'd0, 16'h3002, 16'h0, 255);
        check("tmo_req_len", last_req_len, TMO);
        check("tmo_err", err, 1);
        issue(2'd2, 16'h3003, 16'h1111, 1);
        check("err_sticky", err, 1);

        // Async reset in the middle of a request
        @(posedge clk); #1;
        ack_delay = 255; M_Addr = 16'h3004; mem_state = 2'd0;
        repeat (3) @(posedge clk);
        #3; rst = 1'b0;
        #1;
        check("arst_req", dmem_req, 0);
        check("arst_err", err, 0);
        check("arst_busy", busy, 0);
        check("arst_memout", memout, 0);
        mem_state = 2'd3;
        m_ind_v = 1'b0; m_memout = '0; m_err = 1'b0; m_last = 2'd3;
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        issue(2'd0, 16'h3000, 16'h0, 3);
        check("post_rst_err", err, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
